// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_pkg;

    // Packer states: gathering lanes, or presenting a finished word downstream.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PACK    = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Idle counter for partial-word flush. Counts cycles while a partial word sits
// with nothing in flight; saturates at TIMEOUT and reports expiry.
module fifo_rd_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] r_cnt;

    // Count idle cycles up to the limit; any capture or leaving FILL restarts it.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops PACK lanes of WIDTH bits from a first-word-
// fall-behind FIFO (data arrives the cycle after the pop) and presents them
// as one word with a per-lane keep mask.
// Handshake: a word transfers on a cycle where word_valid && word_ready are
// both high; word_valid never drops and the word never changes before that.
// Optional feature: define FIFO_RD_PACKER_TIMEOUT_EN to flush a partial word
// after TIMEOUT idle cycles (unfilled lanes read 0, keep marks filled lanes).
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PACK    = DEF_PACK,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [WIDTH-1:0]      fifo_data,
    output logic [WIDTH*PACK-1:0] word_data,
    output logic [PACK-1:0]       word_keep,
    output logic                  word_valid,
    input  logic                  word_ready,
    output state_t                o_dbg_state
);
    localparam int CW = $clog2(PACK) + 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);
    localparam logic [CW-1:0] PACK_CNT  = CW'(PACK);

    if (PACK < 2 || (PACK & (PACK - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_rd_packer: PACK must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_req_cnt;
    logic [CW-1:0]         r_lane_cnt;
    logic                  r_pend;
    logic [WIDTH*PACK-1:0] r_data;
    logic [PACK-1:0]       r_keep;

    logic w_last_capture;
    logic w_handshake;
    logic w_flush;

    // r_pend marks a pop accepted last cycle whose data is on fifo_data now.
    assign w_last_capture = r_pend && (r_lane_cnt == LAST_LANE);
    assign w_handshake    = (r_state == HOLD) && word_ready;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic w_idle_inc;
    logic w_idle_clear;
    logic w_idle_expired;

    // Idle means a partial word exists and nothing is waiting to be captured.
    assign w_idle_inc   = (r_state == FILL) && (r_lane_cnt != '0) && !r_pend;
    assign w_idle_clear = r_pend || (r_state != FILL);

    fifo_rd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk     (rd_clk),
        .i_reset   (rd_reset),
        .i_inc     (w_idle_inc),
        .i_clear   (w_idle_clear),
        .o_expired (w_idle_expired)
    );

    // Never flush while a pop is issuing or landing, so no byte is lost.
    assign w_flush = w_idle_expired && (r_state == FILL) && !r_pend && !rd_en;
`else
    assign w_flush = 1'b0;
`endif

    // State register.
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: finish the word on its last lane (or a flush), release on handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL: begin
                if (w_last_capture || w_flush) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // Outputs: pop only while filling, with room, and never during reset.
    always_comb begin
        rd_en       = !rd_reset && (r_state == FILL) && !empty && (r_req_cnt < PACK_CNT);
        word_valid  = (r_state == HOLD);
        word_data   = r_data;
        word_keep   = r_keep;
        o_dbg_state = r_state;
    end

    // Datapath: track pops, land returning data into the next lane, clear on handshake.
    always_ff @(posedge rd_clk) begin
        if (rd_reset || w_handshake) begin
            r_req_cnt  <= '0;
            r_lane_cnt <= '0;
            r_pend     <= 1'b0;
            r_data     <= '0;
            r_keep     <= '0;
        end else if (r_state == FILL) begin
            r_pend <= rd_en;
            if (rd_en) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (r_pend) begin
                for (int k = 0; k < PACK; k++) begin
                    if (r_lane_cnt == CW'(k)) begin
                        r_data[k*WIDTH +: WIDTH] <= fifo_data;
                        r_keep[k]                <= 1'b1;
                    end
                end
                r_lane_cnt <= r_lane_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: FIFO read-data width in bits.
REQ-002 SHALL have parameter PACK, default 4: lanes per output word; power of two, >= 2.
REQ-003 SHALL have parameter TIMEOUT, default 16: idle cycles before partial flush (used only under REQ-030).
REQ-004 SHALL have port rd_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rd_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port empty  input  1  FIFO empty flag, rd_clk domain.
REQ-007 SHALL have port rd_en  output  1  FIFO pop request.
REQ-008 SHALL have port fifo_data  input  WIDTH  FIFO read data, valid the cycle after an accepted pop.
REQ-009 SHALL have port word_data  output  WIDTH*PACK  packed word.
REQ-010 SHALL have port word_keep  output  PACK  per-lane valid mask.
REQ-011 SHALL have port word_valid  output  1  word available.
REQ-012 SHALL have port word_ready  input  1  downstream accepts word.

Function
REQ-013 Accepted pop = rd_en && !empty in cycle t; fifo_data SHALL be captured in cycle t+1.
REQ-014 States FILL and HOLD; rd_en SHALL be state==FILL && !empty && req_cnt < PACK, and 0 otherwise.
REQ-015 req_cnt SHALL count accepted pops in the current word; lane_cnt SHALL count captured lanes.
REQ-016 Lane k SHALL occupy word_data[k*WIDTH +: WIDTH]; the first captured byte goes to lane 0.
REQ-017 Capture of lane PACK-1 in cycle t+1 SHALL move FILL->HOLD, with word_valid=1 and word_keep all-ones from cycle t+2.
REQ-018 Minimum latency: pops in cycles 0..PACK-1 SHALL give word_valid high in cycle PACK+1.
REQ-019 In HOLD, word_data, word_keep and word_valid SHALL remain stable until word_valid && word_ready.
REQ-020 The handshake cycle SHALL clear req_cnt, lane_cnt, word_data and word_keep, and return the block to FILL; rd_en may assert in the next cycle.
REQ-021 empty high mid-word SHALL deassert rd_en, retain captured lanes and keep word_valid low.
REQ-022 word_ready while word_valid is low SHALL be ignored.
REQ-023 No pop SHALL issue in HOLD; the FIFO is never popped beyond PACK per word.

Reset
REQ-024 rd_reset high SHALL force rd_en=0 combinationally in the same cycle.
REQ-025 At the next edge, state=FILL; req_cnt, lane_cnt, the pending-capture flag, word_data, word_keep and word_valid SHALL all be 0.
REQ-026 Reset mid-word SHALL discard partial lanes; a read in flight SHALL NOT be captured.
REQ-027 First rd_en SHALL be possible in the first cycle after rd_reset deasserts.

Configuration
REQ-028 Macro FIFO_RD_PACKER_TIMEOUT_EN SHALL enable partial-word flush.
REQ-029 Timeout counting: in FILL with lane_cnt > 0, no pop outstanding and no capture, an idle counter SHALL increment; any capture SHALL clear it.
REQ-030 Timeout flush: idle counter == TIMEOUT SHALL enter HOLD with word_keep[k]=1 only for filled lanes; unfilled lanes SHALL read 0.
REQ-031 Without the macro: no idle counter; partial words SHALL wait indefinitely; word_keep SHALL be all-ones whenever word_valid=1.

Structure
REQ-032 Package fifo_pkg SHALL hold the state enum (FILL, HOLD) and default WIDTH/PACK constants.
REQ-033 Idle counter SHALL be sub-module fifo_rd_idle_timer, instantiated only under FIFO_RD_PACKER_TIMEOUT_EN.

Verification
REQ-034 Bench SHALL cover: FIFO holds 0x11,0x22,0x33,0x44, word_ready=1 -> pops cycles 0-3, word_data=0x44332211, keep=4'hF, valid in cycle 5.
REQ-035 Bench SHALL cover: 8 bytes 0x01..0x08 with word_ready low for 10 cycles -> first word 0x04030201 held stable, no pop during HOLD, then 0x08070605.
REQ-036 Bench SHALL cover: 2 bytes 0xAA,0xBB then empty for 40 cycles; macro off -> valid stays 0; macro on -> valid after 16 idle cycles, word_data=0x0000BBAA, keep=4'b0011.
REQ-037 Bench SHALL cover: rd_reset pulse after 3 captured lanes -> outputs 0, next word starts at lane 0 with fresh bytes.
REQ-038 Bench SHALL cover: empty toggling every cycle with 4 bytes -> exactly 4 pops, one word 0x44332211, rd_en never high while empty is high.
